// File: rtl/sensor_pkg.sv
// VL53L0X bus constants and the range-poller state encoding.
// Shared by the poller top and anything that decodes state_out.
package sensor_pkg;

   localparam logic [6:0]  VL53L0X_ADDR     = 7'h29;
   localparam logic [7:0]  RANGE_RESULT_REG = 8'h1E;
   localparam logic [3:0]  RANGE_BYTES      = 4'd2;
   localparam logic [15:0] OOR_MM           = 16'd8190;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_START     = 4'd1,
      ST_WAIT_DONE = 4'd2,
      ST_POP_HI    = 4'd3,
      ST_CAP_HI    = 4'd4,
      ST_POP_LO    = 4'd5,
      ST_CAP_LO    = 4'd6,
      ST_DRAIN     = 4'd7,
      ST_PUBLISH   = 4'd8,
      ST_FAIL      = 4'd9
   } poll_state_t;

   function automatic logic is_oor(
      input logic [15:0] mm
   );
      return mm >= OOR_MM;
   endfunction

endpackage

// File: rtl/poll_timer.sv
// Poll-rate divider: counts while enabled and emits a registered
// one-cycle tick on each wrap; held at zero while disabled.
module poll_timer #(
   parameter int unsigned POLL_CYCLES = 900000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CW = $clog2(POLL_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(POLL_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (!enable) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (count == LAST) begin
         count <= '0;
         tick  <= 1'b1;
      end else begin
         count <= count + CW'(1);
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/tof_range_poller.sv
// Periodic VL53L0X range sequencer: triggers a 2-byte register read,
// pops the result FIFO and publishes a validated millimetre sample.
module tof_range_poller
   import sensor_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR       = VL53L0X_ADDR,
   parameter logic [7:0]  RANGE_REG      = RANGE_RESULT_REG,
   parameter int unsigned POLL_CYCLES    = 900000,
   parameter int unsigned TIMEOUT_CYCLES = 270000,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic        rd_start,
   output logic [6:0]  rd_dev_address,
   output logic [7:0]  rd_reg_address,
   output logic [3:0]  rd_byte_width,
   input  logic        rd_done,
   input  logic        rd_failure,
   input  logic [7:0]  fifo_data,
   input  logic        fifo_empty,
   input  logic        fifo_read_valid,
   output logic        fifo_read_en,
   output logic [15:0] range_mm,
   output logic        range_valid,
   output logic        range_oor,
   output logic        sensor_fault,
   output logic [3:0]  state_out
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT_CYCLES);
   localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

   poll_state_t   state;
   logic          tick;
   logic          enable_q;
   logic          done_q;
   logic          drain_wait;
   logic [TW-1:0] tcnt;
   logic [3:0]    retry;
   logic [7:0]    hi_byte;
   logic [7:0]    lo_byte;
   logic          done_rise;
   logic          timed_out;
   logic          pop_state;

   poll_timer #(
      .POLL_CYCLES (POLL_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .tick   (tick)
   );

   assign rd_dev_address = DEV_ADDR;
   assign rd_reg_address = RANGE_REG;
   assign rd_byte_width  = RANGE_BYTES;
   assign state_out      = state;

   assign done_rise = rd_done & ~done_q;
   assign timed_out = (tcnt >= T_LAST);

   // Pop in the POP cycle itself so the byte is valid in the CAP cycle.
   always_comb begin
      pop_state = 1'b0;
      unique case (1'b1)
         (state == ST_POP_HI): pop_state = 1'b1;
         (state == ST_POP_LO): pop_state = 1'b1;
         (state == ST_DRAIN):  pop_state = ~drain_wait;
         default:              pop_state = 1'b0;
      endcase
   end

   assign fifo_read_en = pop_state & ~fifo_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         enable_q     <= 1'b0;
         done_q       <= 1'b0;
         drain_wait   <= 1'b0;
         tcnt         <= '0;
         retry        <= '0;
         hi_byte      <= '0;
         lo_byte      <= '0;
         rd_start     <= 1'b0;
         range_mm     <= '0;
         range_valid  <= 1'b0;
         range_oor    <= 1'b0;
         sensor_fault <= 1'b0;
      end else begin
         enable_q    <= enable;
         done_q      <= rd_done;
         rd_start    <= 1'b0;
         range_valid <= 1'b0;
         if (tcnt != T_SAT) begin
            tcnt <= tcnt + TW'(1);
         end

         unique case (state)
            ST_IDLE: begin
               if (tick && enable) begin
                  state    <= ST_START;
                  rd_start <= 1'b1;
                  tcnt     <= '0;
               end
            end

            ST_START: begin
               state <= ST_WAIT_DONE;
               tcnt  <= '0;
            end

            ST_WAIT_DONE: begin
               if (rd_failure) begin
                  state <= ST_FAIL;
                  tcnt  <= '0;
               end else if (done_rise) begin
                  state <= ST_POP_HI;
                  tcnt  <= '0;
               end else if (timed_out) begin
                  state <= ST_FAIL;
                  tcnt  <= '0;
               end
            end

            ST_POP_HI: begin
               if (!fifo_empty) begin
                  state <= ST_CAP_HI;
                  tcnt  <= '0;
               end else if (timed_out) begin
                  state <= ST_FAIL;
                  tcnt  <= '0;
               end
            end

            ST_CAP_HI: begin
               if (fifo_read_valid) begin
                  hi_byte <= fifo_data;
                  state   <= ST_POP_LO;
                  tcnt    <= '0;
               end else if (timed_out) begin
                  state <= ST_FAIL;
                  tcnt  <= '0;
               end
            end

            ST_POP_LO: begin
               if (!fifo_empty) begin
                  state <= ST_CAP_LO;
                  tcnt  <= '0;
               end else if (timed_out) begin
                  state <= ST_FAIL;
                  tcnt  <= '0;
               end
            end

            ST_CAP_LO: begin
               if (fifo_read_valid) begin
                  lo_byte    <= fifo_data;
                  drain_wait <= 1'b0;
                  state      <= ST_DRAIN;
                  tcnt       <= '0;
               end else if (timed_out) begin
                  state <= ST_FAIL;
                  tcnt  <= '0;
               end
            end

            // Extra bytes are discarded; the wait cycle lets empty settle.
            ST_DRAIN: begin
               if (drain_wait) begin
                  drain_wait <= 1'b0;
               end else if (fifo_empty) begin
                  range_mm    <= {hi_byte, lo_byte};
                  range_oor   <= is_oor({hi_byte, lo_byte});
                  range_valid <= 1'b1;
                  state       <= ST_PUBLISH;
                  tcnt        <= '0;
               end else begin
                  drain_wait <= 1'b1;
               end
            end

            ST_PUBLISH: begin
               retry <= '0;
               state <= ST_IDLE;
               tcnt  <= '0;
            end

            ST_FAIL: begin
               if (retry + 4'd1 == RETRY_MAX) begin
                  sensor_fault <= 1'b1;
               end
               if (retry != RETRY_MAX) begin
                  retry <= retry + 4'd1;
               end
               state <= ST_IDLE;
               tcnt  <= '0;
            end

            default: begin
               state <= ST_IDLE;
               tcnt  <= '0;
            end
         endcase

         if (enable_q && !enable) begin
            sensor_fault <= 1'b0;
            retry        <= '0;
         end
      end
   end

endmodule

// File: tb/tb_tof_range_poller.sv
// Range poller bench: a read-stage/FIFO model feeds planned transactions
// and a scoreboard predicts samples, faults and timing.
module tb_tof_range_poller;

   localparam int unsigned POLL = 40;
   localparam int unsigned TOUT = 12;
   localparam int unsigned MAXR = 3;

   localparam int M_OK     = 0;
   localparam int M_FAIL   = 1;
   localparam int M_SILENT = 2;
   localparam int M_BOTH   = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        rd_start;
   logic [6:0]  rd_dev_address;
   logic [7:0]  rd_reg_address;
   logic [3:0]  rd_byte_width;
   logic        rd_done = 1'b0;
   logic        rd_failure = 1'b0;
   logic [7:0]  fifo_data = 8'h00;
   logic        fifo_empty = 1'b1;
   logic        fifo_read_valid = 1'b0;
   logic        fifo_read_en;
   logic [15:0] range_mm;
   logic        range_valid;
   logic        range_oor;
   logic        sensor_fault;
   logic [3:0]  state_out;

   always #5 clk = ~clk;

   tof_range_poller #(
      .POLL_CYCLES    (POLL),
      .TIMEOUT_CYCLES (TOUT),
      .MAX_RETRY      (MAXR)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .rd_start        (rd_start),
      .rd_dev_address  (rd_dev_address),
      .rd_reg_address  (rd_reg_address),
      .rd_byte_width   (rd_byte_width),
      .rd_done         (rd_done),
      .rd_failure      (rd_failure),
      .fifo_data       (fifo_data),
      .fifo_empty      (fifo_empty),
      .fifo_read_valid (fifo_read_valid),
      .fifo_read_en    (fifo_read_en),
      .range_mm        (range_mm),
      .range_valid     (range_valid),
      .range_oor       (range_oor),
      .sensor_fault    (sensor_fault),
      .state_out       (state_out)
   );

   // read stage + FIFO model
   logic [7:0] fq[$];
   logic [7:0] plan_bytes[$];
   logic [7:0] rs_bytes[$];
   int plan_mode = M_OK;
   int plan_delay = 0;
   int rs_mode = 0;
   int rs_cnt = 0;
   int done_hold = 0;
   bit rs_busy = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         fq.delete();
         rs_busy         <= 1'b0;
         rd_done         <= 1'b0;
         rd_failure      <= 1'b0;
         fifo_read_valid <= 1'b0;
         fifo_empty      <= 1'b1;
         done_hold       <= 0;
      end else begin
         rd_failure      <= 1'b0;
         fifo_read_valid <= 1'b0;
         if (fifo_read_en && fq.size() > 0) begin
            fifo_data       <= fq.pop_front();
            fifo_read_valid <= 1'b1;
         end
         if (done_hold > 0) begin
            done_hold <= done_hold - 1;
            if (done_hold == 1) rd_done <= 1'b0;
         end
         if (rd_start) begin
            rs_busy <= 1'b1;
            rs_cnt  <= plan_delay;
            rs_mode <= plan_mode;
            rs_bytes = plan_bytes;
         end else if (rs_busy) begin
            if (rs_cnt > 0) begin
               rs_cnt <= rs_cnt - 1;
            end else begin
               rs_busy <= 1'b0;
               case (rs_mode)
                  M_OK: begin
                     foreach (rs_bytes[i]) fq.push_back(rs_bytes[i]);
                     rd_done   <= 1'b1;
                     done_hold <= 3;
                  end
                  M_FAIL: rd_failure <= 1'b1;
                  M_BOTH: begin
                     rd_failure <= 1'b1;
                     rd_done    <= 1'b1;
                     done_hold  <= 1;
                  end
                  default: ;
               endcase
            end
         end
         fifo_empty <= (fq.size() == 0);
      end
   end

   // scoreboard
   int checks = 0;
   int failures = 0;
   logic [15:0] exp_mm = '0;
   logic exp_oor = 1'b0;
   logic exp_fault = 1'b0;
   int consec = 0;
   int cur_mode = M_OK;
   int cur_nb = 2;
   logic [15:0] cur_val = '0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic plan(input int mode, input int dly, input int nb,
                       input logic [31:0] bytes);
      plan_mode  = mode;
      plan_delay = dly;
      plan_bytes.delete();
      for (int i = 0; i < nb; i++) plan_bytes.push_back(bytes[31-8*i -: 8]);
      cur_mode = mode;
      cur_nb   = nb;
      cur_val  = bytes[31:16];
   endtask

   task automatic wait_start();
      bit seen = 1'b0;
      for (int i = 0; i < 2*POLL + 10; i++) begin
         @(negedge clk);
         if (rd_start) begin
            seen = 1'b1;
            break;
         end
      end
      chk("start_seen", 32'(seen), 1);
   endtask

   task automatic measure_start();
      int n = 0;
      @(posedge clk);
      #1 enable = 1'b1;
      for (int i = 0; i < 2*POLL; i++) begin
         @(posedge clk);
         n++;
         #1;
         if (rd_start) break;
      end
      chk("first_start", 32'(n), POLL + 1);
   endtask

   task automatic finish_poll();
      int cyc = 0;
      int rise = -1000;
      int vcyc = 0;
      int nvalid = 0;
      int npop = 0;
      int nwait = 0;
      bit ended = 1'b0;
      logic prev_done;
      logic [15:0] mm_v = '0;
      logic oor_v = 1'b0;
      logic emp_v = 1'b0;
      prev_done = rd_done;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         cyc++;
         if (rd_done && !prev_done && rise < 0) rise = cyc;
         prev_done = rd_done;
         if (range_valid) begin
            nvalid++;
            vcyc  = cyc;
            mm_v  = range_mm;
            oor_v = range_oor;
            emp_v = fifo_empty;
         end
         if (fifo_read_en) npop++;
         if (state_out == 4'd2) nwait++;
         if (state_out == 4'd0) begin
            ended = 1'b1;
            break;
         end
      end
      chk("txn_end", 32'(ended), 1);
      if (cur_mode == M_OK) begin
         exp_mm  = cur_val;
         exp_oor = (cur_val >= 16'd8190);
         consec  = 0;
         chk("valid_cnt", 32'(nvalid), 1);
         chk("range_mm", 32'(mm_v), 32'(exp_mm));
         chk("range_oor", 32'(oor_v), 32'(exp_oor));
         chk("empty_at_pub", 32'(emp_v), 1);
         chk("latency", 32'(vcyc - rise), 32'(6 + 2*(cur_nb - 2)));
         chk("pops", 32'(npop), 32'(cur_nb));
      end else begin
         consec++;
         if (consec >= int'(MAXR)) exp_fault = 1'b1;
         chk("valid_cnt", 32'(nvalid), 0);
         chk("pops", 32'(npop), 0);
         if (cur_mode == M_SILENT) chk("wait_cycles", 32'(nwait), TOUT);
      end
      chk("hold_mm", 32'(range_mm), 32'(exp_mm));
      chk("hold_oor", 32'(range_oor), 32'(exp_oor));
      chk("fault", 32'(sensor_fault), 32'(exp_fault));
   endtask

   task automatic run_poll(input int mode, input int dly, input int nb,
                           input logic [31:0] bytes);
      plan(mode, dly, nb, bytes);
      wait_start();
      finish_poll();
   endtask

   task automatic idle_check();
      int n = 0;
      for (int i = 0; i < 2*POLL + 5; i++) begin
         @(negedge clk);
         if (rd_start) n++;
      end
      chk("idle_no_start", 32'(n), 0);
   endtask

   task automatic zero_check(input string tag);
      chk({tag, "_start"}, 32'(rd_start), 0);
      chk({tag, "_pop"}, 32'(fifo_read_en), 0);
      chk({tag, "_mm"}, 32'(range_mm), 0);
      chk({tag, "_valid"}, 32'(range_valid), 0);
      chk({tag, "_oor"}, 32'(range_oor), 0);
      chk({tag, "_fault"}, 32'(sensor_fault), 0);
      chk({tag, "_state"}, 32'(state_out), 0);
      chk({tag, "_dev"}, 32'(rd_dev_address), 32'h29);
      chk({tag, "_reg"}, 32'(rd_reg_address), 32'h1E);
      chk({tag, "_width"}, 32'(rd_byte_width), 2);
   endtask

   initial begin
      logic [31:0] rv;
      int mode;
      int sel;
      bit seen;

      repeat (3) @(negedge clk);
      zero_check("rst");
      reset = 1'b0;

      plan(M_OK, 2, 2, 32'h012C_0000);
      measure_start();
      finish_poll();
      run_poll(M_OK, 0, 2, 32'h1FFE_0000);
      run_poll(M_OK, 1, 2, 32'h1FFD_0000);
      run_poll(M_SILENT, 0, 0, 32'h0);
      run_poll(M_OK, 3, 4, 32'h0064_AABB);

      for (int i = 0; i < 3; i++) run_poll(M_FAIL, i, 0, 32'h0);
      run_poll(M_OK, 1, 2, 32'h0BB8_0000);

      @(negedge clk);
      enable    = 1'b0;
      exp_fault = 1'b0;
      consec    = 0;
      repeat (3) @(negedge clk);
      chk("fault_clear", 32'(sensor_fault), 0);
      idle_check();
      plan(M_BOTH, 1, 0, 32'h0);
      measure_start();
      finish_poll();

      for (int i = 0; i < 16; i++) begin
         sel = $urandom_range(0, 9);
         mode = (sel < 6) ? M_OK : (sel < 8) ? M_FAIL :
                (sel == 8) ? M_SILENT : M_BOTH;
         rv = $urandom;
         if ($urandom_range(0, 3) == 0) rv[31:16] = 16'(8188 + $urandom_range(0, 4));
         run_poll(mode, $urandom_range(0, 4), 2 + $urandom_range(0, 2), rv);
      end

      plan(M_OK, 2, 3, 32'h0457_9900);
      wait_start();
      enable    = 1'b0;
      exp_fault = 1'b0;
      consec    = 0;
      finish_poll();
      idle_check();
      plan(M_OK, 0, 2, 32'h0320_0000);
      measure_start();
      finish_poll();

      plan(M_OK, 1, 2, 32'h0BB8_0000);
      wait_start();
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (state_out == 4'd6) begin
            seen = 1'b1;
            break;
         end
      end
      chk("reach_cap_lo", 32'(seen), 1);
      reset  = 1'b1;
      enable = 1'b0;
      #1;
      zero_check("midrst");
      exp_mm    = '0;
      exp_oor   = 1'b0;
      exp_fault = 1'b0;
      consec    = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      plan(M_OK, 1, 2, 32'h00FA_0000);
      measure_start();
      finish_poll();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tof_range_poller.md
# tof_range_poller

Periodic range-acquisition sequencer for the VL53L0X time-of-flight sensor. It sits directly downstream of, and drives, the I2C register-read stage. It triggers a 2-byte read of the range result register at a fixed poll rate, pops both bytes from the read stage's result FIFO and assembles a 16-bit millimetre distance. It presents that distance to the piano key-detection logic as a validated sample, with retry and fault reporting.

## Interface
Parameters:
- DEV_ADDR, 7'h29, sensor I2C address driven to the read stage
- RANGE_REG, 8'h1E, range result register (MSB at RANGE_REG, LSB at RANGE_REG+1)
- POLL_CYCLES, 900000, clk cycles between poll starts (30 Hz at 27 MHz), >= 2
- TIMEOUT_CYCLES, 270000, max cycles waiting for rd_done/rd_failure or a FIFO byte (10 ms)
- MAX_RETRY, 3, consecutive failed polls before sensor_fault asserts, 1..15

Ports:
- clk  in  1  27 MHz system clock
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  polling runs while high
- rd_start  out  1  one-cycle start pulse to the read stage
- rd_dev_address  out  7  constant DEV_ADDR
- rd_reg_address  out  8  constant RANGE_REG
- rd_byte_width  out  4  constant 4'd2
- rd_done  in  1  read stage completion (level)
- rd_failure  in  1  read stage message_failure
- fifo_data  in  8  FIFO dout
- fifo_empty  in  1  FIFO empty
- fifo_read_valid  in  1  FIFO valid, one cycle after fifo_read_en
- fifo_read_en  out  1  FIFO pop request
- range_mm  out  16  last good distance, held between updates
- range_valid  out  1  one-cycle pulse when range_mm updates
- range_oor  out  1  range_mm >= 8190 (sensor out-of-range code); updated with range_mm
- sensor_fault  out  1  sticky; MAX_RETRY consecutive failures
- state_out  out  4  debug state code

## Operation
- Reset: every output is 0 except the constants rd_dev_address, rd_reg_address and rd_byte_width. State is IDLE. Poll counter, retry count and timeout counter are all 0.
- Poll counter counts 0..POLL_CYCLES-1 and wraps while enable is high. The wrap produces a tick. The counter is held at 0 while enable is low.
- States (state_out code):
  - IDLE(0): on tick -> START.
  - START(1): rd_start=1 for exactly this cycle; clear timeout counter -> WAIT_DONE.
  - WAIT_DONE(2):
    - rd_failure -> FAIL.
    - Rising edge of rd_done (registered previous value 0, current 1) -> POP_HI.
    - Timeout -> FAIL.
    - If rd_failure and rd_done are both high in the same cycle, failure wins.
  - POP_HI(3): if !fifo_empty, fifo_read_en=1 for one cycle -> CAP_HI. Timeout while empty -> FAIL.
  - CAP_HI(4): on fifo_read_valid, latch fifo_data into hi byte -> POP_LO. Timeout -> FAIL.
  - POP_LO(5) and CAP_LO(6): same as POP_HI/CAP_HI for the lo byte; CAP_LO -> DRAIN.
  - DRAIN(7): while !fifo_empty, pop and discard one byte per two cycles. When empty -> PUBLISH.
  - PUBLISH(8): range_mm <= {hi,lo}; range_oor <= ({hi,lo} >= 16'd8190); range_valid=1; retry count <= 0 -> IDLE.
  - FAIL(9): if retry count+1 == MAX_RETRY, set sensor_fault; saturate retry count; range_mm unchanged -> IDLE.
- Timeout counter is cleared on every state change and saturates at TIMEOUT_CYCLES.
- Ticks arriving outside IDLE are dropped, not queued.
- enable low: the current transaction finishes (no abandoned I2C or FIFO operations), then the block stays in IDLE. Falling edge of enable clears sensor_fault and the retry count.
- sensor_fault does not stop polling. A later successful poll does not clear it.

## Timing
- rd_start asserts 1 cycle after the tick (IDLE->START registered).
- fifo_read_en is a single-cycle pulse. The data byte is captured only in the fifo_read_valid cycle, expected 1 cycle after the pop.
- Minimum latency from rd_done rise to range_valid: POP_HI, CAP_HI, POP_LO, CAP_LO, DRAIN(empty), PUBLISH = 6 cycles.
- range_mm, range_oor and range_valid change in the same cycle.
- Asynchronous reset mid-transaction: outputs clear immediately. The read stage and FIFO are recovered by their own reset.

## Structure
- Shared package (sensor_pkg): VL53L0X address and register constants, state encoding, OOR threshold 8190.
- A single sub-module is natural: poll_timer (divider plus enable gating, emits tick). Everything else lives in one FSM.

## Test plan
- Read stage model returns bytes 0x01,0x2C with rd_done -> range_valid pulse, range_mm=300, range_oor=0, 6 cycles after rd_done rise.
- Bytes 0x1F,0xFE -> range_mm=8190, range_oor=1.
- rd_failure on 3 consecutive polls (MAX_RETRY=3) -> sensor_fault=1 on the third FAIL; range_mm keeps its prior value; enable toggled low -> sensor_fault=0.
- rd_done never asserts -> FAIL after TIMEOUT_CYCLES; no fifo_read_en issued.
- FIFO holds 4 bytes 0x00,0x64,0xAA,0xBB -> range_mm=100; two discard pops; fifo_empty before PUBLISH.
- reset asserted in CAP_LO -> all outputs 0 immediately; after release, the first rd_start comes POLL_CYCLES+1 cycles after enable.
